cia_timer: RTL and testbench

Register-mapped interval-timer and interrupt controller that sits directly downstream of the 6510 core on its external bus, decoding CPU bus cycles and driving the core's IRQn input. Provides two 16-bit down-counters with reload latches, one-shot/continuous modes and Timer B cascade, plus a 6526-style interrupt flag/mask register. Read data is returned on the CPU data bus during read cycles.

---
 rtl/cia_timer_pkg.sv | 19 +
 rtl/cia_timer_counter.sv | 51 +++++
 rtl/cia_timer.sv | 81 ++++++++
 tb/tb_cia_timer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cia_timer_pkg.sv
// cia_timer_pkg: register map, control/ICR bit positions and reset constants for cia_timer
package cia_timer_pkg;
  localparam logic [3:0] A_TALO = 4'h0;
  localparam logic [3:0] A_TAHI = 4'h1;
  localparam logic [3:0] A_TBLO = 4'h2;
  localparam logic [3:0] A_TBHI = 4'h3;
  localparam logic [3:0] A_ICR  = 4'h4;
  localparam logic [3:0] A_CRA  = 4'h5;
  localparam logic [3:0] A_CRB  = 4'h6;
  localparam int CR_START      = 0;
  localparam int CR_ONESHOT    = 3;
  localparam int CR_FORCE_LOAD = 4;
  localparam int CR_INMODE     = 5;
  localparam int ICR_FA  = 0;
  localparam int ICR_FB  = 1;
  localparam int ICR_SET = 7;
  localparam int ICR_IR  = 7;
  localparam logic [15:0] LATCH_RST = 16'hFFFF;
endpackage

// File: rtl/cia_timer_counter.sv
// cia_timer_counter: 16-bit reload latch and down-counter with START/ONESHOT control
// Ports: clk, rst_n (async active low), count_en (count event), wr_lo/wr_hi/wr_cr (register
// write strobes), d_in (write data), cnt (live counter), cr (control register read view),
// underflow (combinational, asserted in the clk the counter wraps)
module cia_timer_counter
  import cia_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic        wr_cr,
  input  logic [7:0]  d_in,
  output logic [15:0] cnt,
  output logic [7:0]  cr,
  output logic        underflow
);
  logic [15:0] latch, latch_nxt;
  logic        start, oneshot, inmode, load;
  // counting uses the registered START, so a write that starts the timer never counts in its own clk
  always_comb begin
    latch_nxt = wr_lo ? {latch[15:8], d_in} : wr_hi ? {d_in, latch[7:0]} : latch;
    load = (wr_cr & d_in[CR_FORCE_LOAD]) | (wr_hi & !start);
    underflow = count_en & start & !load & (cnt == 16'd0);
    cr = 8'h00;
    cr[CR_START] = start;
    cr[CR_ONESHOT] = oneshot;
    cr[CR_INMODE] = inmode;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch <= LATCH_RST;
      cnt <= LATCH_RST;
      start <= 1'b0;
      oneshot <= 1'b0;
      inmode <= 1'b0;
    end else begin
      latch <= latch_nxt;
      if (load || underflow) cnt <= latch_nxt;
      else if (count_en && start) cnt <= cnt - 16'd1;
      if (wr_cr) begin
        start <= d_in[CR_START];
        oneshot <= d_in[CR_ONESHOT];
        inmode <= d_in[CR_INMODE];
      end else if (underflow && oneshot) begin
        start <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/cia_timer.sv
// cia_timer: 6526-style interval timers with interrupt flag/mask register driving IRQn
// Ports: clk, RESETn (async active low), bus_stb (bus cycle completion), tick (count enable),
// cs_n/addr/rw_n/d_in (CPU bus), d_out/d_oe (read data and drive enable), IRQn (registered)
// Build option: define CIA_TIMER_B_EN to include Timer B, CRB, flag fB and the cascade.
module cia_timer
  import cia_timer_pkg::*;
(
  input  logic       clk,
  input  logic       RESETn,
  input  logic       bus_stb,
  input  logic       tick,
  input  logic       cs_n,
  input  logic [3:0] addr,
  input  logic       rw_n,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       IRQn
);
`ifdef CIA_TIMER_B_EN
  localparam logic [1:0] TMR_EN = 2'b11;
`else
  localparam logic [1:0] TMR_EN = 2'b01;
`endif
  logic        wr, icr_rd, pending;
  logic [1:0]  flags, mask, uf;
  logic [15:0] cnt_a;
  logic [7:0]  cr_a, rd_data, icr_data;
  assign wr = bus_stb & !cs_n & !rw_n;
  assign icr_rd = bus_stb & !cs_n & rw_n & (addr == A_ICR);
  assign d_oe = !cs_n & rw_n;
  assign pending = |(flags & mask);
  cia_timer_counter u_ta (
    .clk(clk), .rst_n(RESETn), .count_en(tick),
    .wr_lo(wr && addr == A_TALO), .wr_hi(wr && addr == A_TAHI), .wr_cr(wr && addr == A_CRA),
    .d_in(d_in), .cnt(cnt_a), .cr(cr_a), .underflow(uf[0])
  );
`ifdef CIA_TIMER_B_EN
  logic [15:0] cnt_b;
  logic [7:0]  cr_b;
  // cascade: a Timer A underflow is a Timer B count event in the same clk
  cia_timer_counter u_tb (
    .clk(clk), .rst_n(RESETn), .count_en(cr_b[CR_INMODE] ? uf[0] : tick),
    .wr_lo(wr && addr == A_TBLO), .wr_hi(wr && addr == A_TBHI), .wr_cr(wr && addr == A_CRB),
    .d_in(d_in), .cnt(cnt_b), .cr(cr_b), .underflow(uf[1])
  );
`else
  assign uf[1] = 1'b0;
`endif
  always_comb begin
    icr_data = 8'h00;
    icr_data[ICR_IR] = pending;
    icr_data[ICR_FB:ICR_FA] = flags;
    case (addr)
      A_TALO:  rd_data = cnt_a[7:0];
      A_TAHI:  rd_data = cnt_a[15:8];
      A_ICR:   rd_data = icr_data;
      A_CRA:   rd_data = cr_a & ~(8'h01 << CR_INMODE);
`ifdef CIA_TIMER_B_EN
      A_TBLO:  rd_data = cnt_b[7:0];
      A_TBHI:  rd_data = cnt_b[15:8];
      A_CRB:   rd_data = cr_b;
`endif
      default: rd_data = 8'h00;
    endcase
    d_out = d_oe ? rd_data : 8'h00;
  end
  // a new underflow beats a simultaneous ICR read clear
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      flags <= 2'b00;
      mask <= 2'b00;
      IRQn <= 1'b1;
    end else begin
      flags <= (uf | (flags & {2{!icr_rd}})) & TMR_EN;
      if (wr && addr == A_ICR)
        mask <= (d_in[ICR_SET] ? (mask | d_in[1:0]) : (mask & ~d_in[1:0])) & TMR_EN;
      IRQn <= !pending;
    end
  end
endmodule

// File: tb/tb_cia_timer.sv
// tb_cia_timer: directed scoreboard bench for cia_timer
module tb_cia_timer;
  import cia_timer_pkg::*;
  logic clk = 1'b0, RESETn = 1'b0, bus_stb = 1'b0, tick = 1'b0, cs_n = 1'b1, rw_n = 1'b1;
  logic chk_stb = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] d_in = 8'h00, d_out;
  logic d_oe, IRQn;
  int n_cmp = 0, n_err = 0;
  typedef struct { string name; int kind; logic [8:0] exp; } exp_t;
  exp_t sb[$];

  cia_timer dut (
    .clk(clk), .RESETn(RESETn), .bus_stb(bus_stb), .tick(tick), .cs_n(cs_n),
    .addr(addr), .rw_n(rw_n), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .IRQn(IRQn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // kind 0: bus read {d_oe,d_out}; kind 1: IRQn; kind 2: idle {d_oe,d_out}
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (chk_stb || (bus_stb && !cs_n && rw_n)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %h required nothing", {d_oe, d_out});
      end else begin
        e = sb.pop_front();
        act = (e.kind == 1) ? {8'h00, IRQn} : {d_oe, d_out};
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %h required %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    cs_n = 1'b0; rw_n = 1'b0; addr = a; d_in = d; bus_stb = 1'b1;
    cyc(1);
    bus_stb = 1'b0; cs_n = 1'b1; rw_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [7:0] x, input string name);
    sb.push_back('{name, 0, {1'b1, x}});
    cs_n = 1'b0; rw_n = 1'b1; addr = a; bus_stb = 1'b1;
    cyc(1);
    bus_stb = 1'b0; cs_n = 1'b1;
  endtask

  task automatic chk_irq(input logic x, input string name);
    sb.push_back('{name, 1, {8'h00, x}});
    chk_stb = 1'b1;
    cyc(1);
    chk_stb = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    sb.push_back('{name, 2, 9'h000});
    cs_n = 1'b1; rw_n = 1'b1; addr = A_TALO; chk_stb = 1'b1;
    cyc(1);
    chk_stb = 1'b0;
  endtask

  initial begin
    cyc(3);
    RESETn = 1'b1;
    cyc(1);
    chk_irq(1'b1, "rst_irqn");
    chk_idle("rst_dout_idle");
    bus_rd(A_TALO, 8'hFF, "rst_talo");
    bus_rd(A_TAHI, 8'hFF, "rst_tahi");
    bus_rd(A_CRA, 8'h00, "rst_cra");
    bus_rd(A_ICR, 8'h00, "rst_icr");
    // continuous, latch 3
    bus_wr(A_TALO, 8'h03);
    bus_wr(A_TAHI, 8'h00);
    bus_wr(A_CRA, 8'h01);
    tick = 1'b1;
    bus_rd(A_TALO, 8'h03, "cont_c3");
    bus_rd(A_TALO, 8'h02, "cont_c2");
    bus_rd(A_TALO, 8'h01, "cont_c1");
    bus_rd(A_TALO, 8'h00, "cont_c0");
    bus_rd(A_TALO, 8'h03, "cont_reload");
    tick = 1'b0;
    bus_rd(A_ICR, 8'h01, "cont_fa");
    bus_rd(A_ICR, 8'h00, "cont_fa_clr");
    bus_wr(A_CRA, 8'h00);
    // one-shot, latch 2
    bus_wr(A_TALO, 8'h02);
    bus_wr(A_TAHI, 8'h00);
    bus_wr(A_CRA, 8'h09);
    tick = 1'b1;
    cyc(6);
    tick = 1'b0;
    bus_rd(A_CRA, 8'h08, "os_cra");
    bus_rd(A_TALO, 8'h02, "os_talo");
    bus_rd(A_TAHI, 8'h00, "os_tahi");
    bus_rd(A_ICR, 8'h01, "os_fa");
    tick = 1'b1;
    cyc(4);
    tick = 1'b0;
    bus_rd(A_ICR, 8'h00, "os_no_second");
    // interrupt timing
    bus_wr(A_ICR, 8'h81);
    bus_wr(A_CRA, 8'h01);
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    chk_irq(1'b1, "irq_n1_high");
    chk_irq(1'b0, "irq_n2_low");
    bus_rd(A_ICR, 8'h81, "irq_icr");
    cyc(1);
    chk_irq(1'b1, "irq_released");
    bus_rd(A_ICR, 8'h00, "irq_icr2");
    // ICR read coincident with underflow
    tick = 1'b1;
    cyc(2);
    bus_rd(A_ICR, 8'h00, "coin_icr");
    tick = 1'b0;
    chk_irq(1'b1, "coin_n1");
    chk_irq(1'b0, "coin_n2_low");
    bus_rd(A_ICR, 8'h81, "coin_fa_kept");
    cyc(1);
    chk_irq(1'b1, "coin_released");
    // mask cleared while pending
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    cyc(1);
    chk_irq(1'b0, "mask_low");
    bus_wr(A_ICR, 8'h01);
    cyc(1);
    chk_irq(1'b1, "mask_cleared_high");
    bus_rd(A_ICR, 8'h01, "mask_flag_kept");
    // force load beats count; start write does not count in its own clk
    bus_wr(A_CRA, 8'h00);
    bus_wr(A_TALO, 8'h05);
    bus_wr(A_CRA, 8'h01);
    tick = 1'b1;
    bus_wr(A_CRA, 8'h11);
    tick = 1'b0;
    bus_rd(A_TALO, 8'h05, "fl_talo");
    bus_rd(A_CRA, 8'h01, "fl_cra");
    bus_wr(A_CRA, 8'h00);
    tick = 1'b1;
    bus_wr(A_CRA, 8'h01);
    tick = 1'b0;
    bus_rd(A_TALO, 8'h05, "start_no_dec");
    bus_wr(A_CRA, 8'h00);
`ifdef CIA_TIMER_B_EN
    // cascade: latch A 0, latch B 1
    bus_wr(A_TALO, 8'h00);
    bus_wr(A_TAHI, 8'h00);
    bus_wr(A_TBLO, 8'h01);
    bus_wr(A_TBHI, 8'h00);
    bus_wr(A_CRB, 8'h21);
    bus_wr(A_CRA, 8'h01);
    tick = 1'b1;
    bus_rd(A_TBLO, 8'h01, "casc_b1");
    bus_rd(A_TBLO, 8'h00, "casc_b0");
    bus_rd(A_TBLO, 8'h01, "casc_b1_reload");
    bus_rd(A_TBLO, 8'h00, "casc_b0_again");
    tick = 1'b0;
    bus_rd(A_CRB, 8'h21, "casc_crb");
    bus_rd(A_ICR, 8'h03, "casc_flags");
    bus_wr(A_CRA, 8'h00);
    bus_wr(A_CRB, 8'h00);
`else
    bus_wr(A_TBLO, 8'h55);
    bus_wr(A_CRB, 8'h21);
    bus_rd(A_TBLO, 8'h00, "nob_tblo");
    bus_rd(A_TBHI, 8'h00, "nob_tbhi");
    bus_rd(A_CRB, 8'h00, "nob_crb");
    bus_wr(A_ICR, 8'h83);
    bus_rd(A_ICR, 8'h00, "nob_icr");
    bus_wr(A_ICR, 8'h01);
`endif
    bus_rd(4'h9, 8'h00, "unmapped");
    chk_idle("idle_dout");
    // reset mid-count
    bus_wr(A_TALO, 8'h01);
    bus_wr(A_TAHI, 8'h00);
    bus_wr(A_ICR, 8'h81);
    bus_wr(A_CRA, 8'h01);
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    cyc(1);
    chk_irq(1'b0, "prerst_irq_low");
    #2 RESETn = 1'b0;
    chk_irq(1'b1, "inrst_irqn");
    bus_rd(A_TALO, 8'hFF, "inrst_talo");
    RESETn = 1'b1;
    bus_rd(A_TALO, 8'hFF, "postrst_talo");
    bus_rd(A_TAHI, 8'hFF, "postrst_tahi");
    bus_rd(A_CRA, 8'h00, "postrst_cra");
    bus_rd(A_ICR, 8'h00, "postrst_icr");
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    bus_rd(A_TALO, 8'hFF, "postrst_stopped");
`ifdef CIA_TIMER_B_EN
    bus_rd(A_TBLO, 8'hFF, "postrst_tblo");
`endif
    chk_irq(1'b1, "postrst_irqn");
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL unobserved: got %0d pending entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
